branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-stage dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters.
//  Predicts direction and target for the IF-stage PC.
//  Trained by the branch resolving in EX.
//  Drives branch_predicted into the hazard unit, which flushes ID/EX on a mispredict.
//  Supplies the corrected fetch PC for the redirect.
// PARAMETERS
//  ENTRIES  16  BTB entries; power of two, >=2. IDX=$clog2(ENTRIES); tag = pc[31:IDX+2]
// PORTS
//  CLK             in   1   system clock, rising edge
//  nRST            in   1   async active-low reset
//  if_pc           in   32  PC being fetched this cycle
//  predict_taken   out  1   IF prediction: taken
//  predict_target  out  32  next fetch PC per prediction
//  stall           in   1   pipeline stall from hazard unit (EX instruction held)
//  ex_branch       in   1   BEQ/BNE valid in EX this cycle
//  ex_pc           in   32  PC of the EX branch
//  ex_taken        in   1   resolved direction
//  ex_target       in   32  resolved taken target
//  ex_pred_taken   in   1   prediction carried down the pipe with the branch
//  ex_pred_target  in   32  predicted next PC carried with the branch
//  branch_predicted out 1   1 = EX branch prediction correct (or no branch in EX)
//  correct_pc      out  32  ex_taken ? ex_target : ex_pc+4
// BEHAVIOUR
//  State per entry:
//   - valid, tag, target[31:0], ctr[1:0]: 00 SNT, 01 WNT, 10 WT, 11 ST.
//  Reset (async, nRST=0):
//   - All valid=0, ctr=01, target=0.
//   - Outputs are combinational from state, so after reset predict_taken=0 and predict_target=if_pc+4.
//  Lookup (combinational, 0-cycle):
//   - idx=if_pc[IDX+1:2]; hit = valid[idx] && tag[idx]==if_pc[31:IDX+2].
//   - predict_taken = hit && ctr[idx][1].
//   - predict_target = predict_taken ? target[idx] : if_pc+4 (32-bit wrap).
//  Update (on posedge when upd = ex_branch && !stall):
//   - Writes entry at idx of ex_pc.
//   - Tag hit: ctr saturating +1 if ex_taken, else -1 (ST stays ST, SNT stays SNT).
//   - Miss: allocate (overwrite) with valid=1, new tag, ctr = ex_taken ? 10 : 01.
//   - target <= ex_target on every update (hit or allocate).
//   - stall=1 blocks the update, so a held EX branch trains exactly once.
//  Same-cycle lookup and update to the same idx:
//   - Lookup returns the pre-update contents; there is no write-to-read bypass.
//  branch_predicted (combinational):
//   - 1 when !ex_branch.
//   - Otherwise 1 iff ex_pred_taken==ex_taken && (!ex_taken || ex_pred_target==ex_target).
//   - Valid regardless of stall.
//  correct_pc:
//   - Always computed; consumers use it only when branch_predicted=0.
//  Reset mid-training clears all entries immediately; there are no pending writes.
// CONFIGURATION
//  BP_STATS_EN defined:
//   - Adds out ports stat_branches[31:0] and stat_mispredicts[31:0], reset to 0.
//   - On each upd, stat_branches+1; stat_mispredicts+1 if branch_predicted=0.
//   - Both counters saturate at 32'hFFFFFFFF.
//  BP_STATS_EN undefined: ports and counters absent; no other behaviour changes.
// TESTING
//  T1 reset, if_pc=0x100 -> predict_taken=0, predict_target=0x104
//  T2 upd ex_pc=0x100 taken tgt=0x200 -> next cycle if_pc=0x100: taken, target 0x200
//  T3 then upd 0x100 not-taken -> ctr=01, predict_taken=0, target 0x104
//  T4 3x upd 0x100 taken (reaches 11) then 1x not-taken -> still predicts taken (10)
//  T5 alias: train 0x100 taken, upd 0x140 not-taken (ENTRIES=16) -> 0x100 misses: not taken, 0x104
//  T6 ex_branch=1, stall=1 for 1 cycle then 0, ex_pred_taken=1, pred 0x200, actual taken 0x204:
//     -> branch_predicted=0 both cycles, correct_pc=0x204, one update only
//     -> with BP_STATS_EN: stat_branches=1, stat_mispredicts=1

Source files
------------

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup and EX training/redirect signals of the branch predictor
// Stats counters appear only when BP_STATS_EN is defined.
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        stall;
  logic        ex_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        branch_predicted;
  logic [31:0] correct_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output if_pc, stall, ex_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    input  predict_taken, predict_target, branch_predicted, correct_pc,
    input  stat_branches, stat_mispredicts
  );
  modport slave (
    input  if_pc, stall, ex_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    output predict_taken, predict_target, branch_predicted, correct_pc,
    output stat_branches, stat_mispredicts
  );
`else
  modport master (
    output if_pc, stall, ex_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    input  predict_taken, predict_target, branch_predicted, correct_pc
  );
  modport slave (
    input  if_pc, stall, ex_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    output predict_taken, predict_target, branch_predicted, correct_pc
  );
`endif
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit saturating counters for the IF stage
// Optional BP_STATS_EN adds saturating branch / mispredict counters.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input logic              CLK,
  input logic              nRST,
  branch_predictor_if.slave bp
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX-1:0]   rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic [IDX-1:0]   wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;
  logic             upd;
  logic [1:0]       ctr_next;

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign rd_idx = bp.if_pc[IDX+1:2];
  assign rd_tag = bp.if_pc[31:IDX+2];
  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

  assign bp.predict_taken  = rd_hit && ctr_q[rd_idx][1];
  assign bp.predict_target = bp.predict_taken ? target_q[rd_idx] : bp.if_pc + 32'd4;

  assign bp.branch_predicted = !bp.ex_branch ||
                               ((bp.ex_pred_taken == bp.ex_taken) &&
                                (!bp.ex_taken || (bp.ex_pred_target == bp.ex_target)));
  assign bp.correct_pc       = bp.ex_taken ? bp.ex_target : bp.ex_pc + 32'd4;

  // A stalled EX branch is held for several cycles but must train only once.
  assign upd    = bp.ex_branch && !bp.stall;
  assign wr_idx = bp.ex_pc[IDX+1:2];
  assign wr_tag = bp.ex_pc[31:IDX+2];
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_comb begin
    ctr_next = ctr_q[wr_idx];
    if (wr_hit) begin
      if (bp.ex_taken) begin
        if (ctr_q[wr_idx] != 2'b11) ctr_next = ctr_q[wr_idx] + 2'd1;
      end else begin
        if (ctr_q[wr_idx] != 2'b00) ctr_next = ctr_q[wr_idx] - 2'd1;
      end
    end else begin
      ctr_next = bp.ex_taken ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= bp.ex_target;
      ctr_q[wr_idx]    <= ctr_next;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branches_q;
  logic [31:0] mispredicts_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      branches_q    <= 32'd0;
      mispredicts_q <= 32'd0;
    end else if (upd) begin
      if (branches_q != 32'hFFFF_FFFF) branches_q <= branches_q + 32'd1;
      if (!bp.branch_predicted && (mispredicts_q != 32'hFFFF_FFFF))
        mispredicts_q <= mispredicts_q + 32'd1;
    end
  end

  assign bp.stat_branches    = branches_q;
  assign bp.stat_mispredicts = mispredicts_q;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and randomized checks of branch_predictor against a table model
// Build with BP_STATS_EN defined to also check the statistics counters.
module tb_branch_predictor;
  localparam int ENT = 16;
  localparam int SH  = $clog2(ENT) + 2;

  logic CLK;
  logic nRST;
  int   n_cmp;
  int   n_bad;
  bit   run_cmp;

  branch_predictor_if bp();
  branch_predictor #(.ENTRIES(ENT)) dut (.CLK(CLK), .nRST(nRST), .bp(bp.slave));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Model: each slot remembers which PC block owns it, a 0..3 confidence and a target.
  bit          m_valid [ENT];
  logic [31:0] m_owner [ENT];
  int          m_conf  [ENT];
  logic [31:0] m_tgt   [ENT];
  logic [31:0] m_branches;
  logic [31:0] m_mispred;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    int s = slot(pc);
    return m_valid[s] && (m_owner[s] == (pc >> SH)) && (m_conf[s] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_correct(input bit br, input bit tk, input logic [31:0] tg,
                                   input bit ptk, input logic [31:0] ptg);
    if (!br) return 1'b1;
    if (ptk != tk) return 1'b0;
    return !tk || (ptg == tg);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 1'b0;
      m_owner[i] = 32'd0;
      m_conf[i]  = 1;
      m_tgt[i]   = 32'd0;
    end
    m_branches = 32'd0;
    m_mispred  = 32'd0;
  endtask

  task automatic m_train();
    int s;
    if (bp.ex_branch && !bp.stall) begin
      s = slot(bp.ex_pc);
      if (m_valid[s] && m_owner[s] == (bp.ex_pc >> SH)) begin
        if (bp.ex_taken) m_conf[s] = (m_conf[s] < 3) ? m_conf[s] + 1 : 3;
        else             m_conf[s] = (m_conf[s] > 0) ? m_conf[s] - 1 : 0;
      end else begin
        m_valid[s] = 1'b1;
        m_owner[s] = bp.ex_pc >> SH;
        m_conf[s]  = bp.ex_taken ? 2 : 1;
      end
      m_tgt[s] = bp.ex_target;
      if (m_branches != 32'hFFFF_FFFF) m_branches = m_branches + 32'd1;
      if (!m_correct(bp.ex_branch, bp.ex_taken, bp.ex_target, bp.ex_pred_taken, bp.ex_pred_target)
          && m_mispred != 32'hFFFF_FFFF)
        m_mispred = m_mispred + 32'd1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (run_cmp && nRST) begin
      check("predict_taken", 32'(bp.predict_taken), 32'(m_taken(bp.if_pc)));
      check("predict_target", bp.predict_target, m_target(bp.if_pc));
      check("branch_predicted", 32'(bp.branch_predicted),
            32'(m_correct(bp.ex_branch, bp.ex_taken, bp.ex_target, bp.ex_pred_taken, bp.ex_pred_target)));
      check("correct_pc", bp.correct_pc, bp.ex_taken ? bp.ex_target : bp.ex_pc + 32'd4);
`ifdef BP_STATS_EN
      check("stat_branches", bp.stat_branches, m_branches);
      check("stat_mispredicts", bp.stat_mispredicts, m_mispred);
`endif
    end
  end

  task automatic tick();
    @(posedge CLK);
    if (nRST) m_train();
    #1;
  endtask

  task automatic drive(input bit br, input bit st, input logic [31:0] pc, input bit tk,
                       input logic [31:0] tg, input bit ptk, input logic [31:0] ptg);
    bp.ex_branch      = br;
    bp.stall          = st;
    bp.ex_pc          = pc;
    bp.ex_taken       = tk;
    bp.ex_target      = tg;
    bp.ex_pred_taken  = ptk;
    bp.ex_pred_target = ptg;
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
    drive(1'b1, 1'b0, pc, tk, tg, m_taken(pc), m_target(pc));
    tick();
  endtask

  task automatic look(input string name, input logic [31:0] pc, input bit exp_tk,
                      input logic [31:0] exp_tg);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    bp.if_pc = pc;
    #2;
    check({name, "_taken"}, 32'(bp.predict_taken), 32'(exp_tk));
    check({name, "_target"}, bp.predict_target, exp_tg);
    tick();
  endtask

  task automatic do_reset();
    #1 nRST = 1'b0;
    m_clear();
    #1;
    @(negedge CLK);
    #1 nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    run_cmp = 1'b0;
    nRST    = 1'b0;
    m_clear();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    bp.if_pc = 32'h100;
    #2;
    check("T1_reset_taken", 32'(bp.predict_taken), 32'd0);
    check("T1_reset_target", bp.predict_target, 32'h104);
    @(negedge CLK);
    #1 nRST = 1'b1;
    @(posedge CLK);
    #1;
    run_cmp = 1'b1;

    upd(32'h100, 1'b1, 32'h200);
    look("T2", 32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h200);
    look("T3", 32'h100, 1'b0, 32'h104);
    repeat (3) upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h200);
    look("T4", 32'h100, 1'b1, 32'h200);
    upd(32'h140, 1'b0, 32'h300);
    look("T5_alias", 32'h100, 1'b0, 32'h104);
    look("T5_owner", 32'h140, 1'b0, 32'h144);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    upd(32'h104, 1'b1, 32'h300);
    look("pre_reset", 32'h104, 1'b1, 32'h300);
    do_reset();
    look("post_reset", 32'h104, 1'b0, 32'h108);

    bp.if_pc = 32'h184;
    drive(1'b1, 1'b1, 32'h184, 1'b1, 32'h204, 1'b1, 32'h200);
    #2;
    check("T6_stall_bp", 32'(bp.branch_predicted), 32'd0);
    check("T6_stall_cpc", bp.correct_pc, 32'h204);
    tick();
    bp.stall = 1'b0;
    #2;
    check("T6_go_bp", 32'(bp.branch_predicted), 32'd0);
    check("T6_go_cpc", bp.correct_pc, 32'h204);
    tick();
`ifdef BP_STATS_EN
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #2;
    check("T6_stat_branches", bp.stat_branches, 32'd1);
    check("T6_stat_mispredicts", bp.stat_mispredicts, 32'd1);
`endif
    look("T6_trained", 32'h184, 1'b1, 32'h204);
    upd(32'h184, 1'b0, 32'h204);
    look("T6_once", 32'h184, 1'b0, 32'h188);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      logic [31:0] tg;
      bit          tk;
      if (i == 1500) do_reset();
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFC0 + 32'($urandom_range(0, 15) * 4)
                                        : 32'($urandom_range(0, 127) * 4);
      tk = $urandom_range(0, 1) == 1;
      tg = ($urandom_range(0, 1) == 1) ? 32'h1000 + 32'($urandom_range(0, 3) * 4)
                                       : $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 1)
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, pc, tk, tg,
              m_taken(pc), m_target(pc));
      else
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, pc, tk, tg,
              $urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? tg : pc + 32'd4);
      bp.if_pc = ($urandom_range(0, 1) == 1) ? pc : 32'($urandom_range(0, 127) * 4);
      tick();
    end

    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
